// File: rtl/alu_pkg.sv
// ALU shared definitions: operand width and opcode encoding.
// Codes 2 and 3 are reserved; the ALU drives a zero result for them.
// Imported by the command issuer and anything that talks to the ALU.
package alu_pkg;

  parameter int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_RSV2 = 2'd2,
    ALU_RSV3 = 2'd3
  } alu_opcode_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of command, ALU-drive and response signals around alu_cmd_issuer.
// No logic: pure wiring; latency is set by the issuer.
// cmd_valid/cmd_ready and rsp_valid/rsp_ready carry the two handshakes.
interface alu_cmd_issuer_if #(
  parameter int W = alu_pkg::DATA_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [W-1:0]          cmd_a;
  logic [W-1:0]          cmd_b;
  alu_pkg::alu_opcode_t  cmd_op;
  logic                  cmd_acc;

  logic [W-1:0]          alu_a;
  logic [W-1:0]          alu_b;
  alu_pkg::alu_opcode_t  alu_op;
  logic [W-1:0]          alu_result;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W-1:0]          rsp_result;
  logic                  rsp_err;

  logic [W-1:0]          acc;
  logic                  busy;

  // Command producer plus the ALU itself
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_err, acc, busy
  );

  // The issuer
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_err, acc, busy
  );

endinterface

// File: rtl/alu_cmd_issuer.sv
// Generic synchronous FIFO with occupancy counter, no write bypass.
// Latency: an entry written at edge N is visible on rd_dat after edge N.
// Backpressure: wr_rdy drops when full; a same-cycle read does not reopen it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign wr_rdy = (count != FULL_CNT);
  assign rd_vld = (count != '0);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the counter alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// Buffers ALU commands and issues them one at a time, returning each result.
// Latency: accept at edge N, ALU driven after N+1, rsp_valid after N+2.
// Backpressure: rsp_ready low parks the FSM in RESPOND while the FIFO fills.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int W     = DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  alu_cmd_issuer_if.slave bus
);

  typedef struct packed {
    logic        acc_sel;
    alu_opcode_t op;
    logic [W-1:0] b;
    logic [W-1:0] a;
  } cmd_t;

  localparam int CW = $bits(cmd_t);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  cmd_t        wr_entry;
  cmd_t        head;
  logic        fifo_vld;
  logic        pop;
  logic        legal;

  logic [W-1:0] alu_a_q;
  logic [W-1:0] alu_b_q;
  alu_opcode_t  alu_op_q;
  logic         rsp_valid_q;
  logic [W-1:0] rsp_result_q;
  logic         rsp_err_q;
  logic [W-1:0] acc_q;

  // acc_sel travels with its command; the operand swap happens at pop time
  assign wr_entry = {bus.cmd_acc, bus.cmd_op, bus.cmd_b, bus.cmd_a};

  sync_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (bus.cmd_valid),
    .wr_rdy (bus.cmd_ready),
    .wr_dat (wr_entry),
    .rd_vld (fifo_vld),
    .rd_rdy (pop),
    .rd_dat (head)
  );

  assign legal = (alu_op_q == ALU_ADD) || (alu_op_q == ALU_SUB);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and FIFO pop: one command in flight at a time
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_vld) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESPOND;
      RESPOND: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU drive on pop, result capture in ISSUE, response release on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= ALU_ADD;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      acc_q        <= '0;
    end else begin
      if (pop) begin
        alu_a_q  <= head.acc_sel ? acc_q : head.a;
        alu_b_q  <= head.b;
        alu_op_q <= head.op;
      end
      if (state == ISSUE) begin
        rsp_valid_q  <= 1'b1;
        rsp_result_q <= legal ? bus.alu_result : '0;
        rsp_err_q    <= !legal;
        if (legal) acc_q <= bus.alu_result;
      end else if ((state == RESPOND) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.acc        = acc_q;
  assign bus.busy       = fifo_vld || (state != IDLE);

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential initiator that drives the combinational `alu` from a buffered command stream. Accepts operand/opcode commands over a valid/ready interface, queues them in a small FIFO, and issues one at a time on the ALU's `a`/`b`/`op` inputs. It captures `result`, updates an internal accumulator, and returns each result over a valid/ready response interface. It sits between a command producer (testbench or controller) and one `alu` instance, and imports `alu_pkg::*` for `DATA_WIDTH` and `alu_opcode_t`.

## Interface
- `W`, default `DATA_WIDTH` (from `alu_pkg`): operand/result width.
- `DEPTH`, default 4: command FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_a`  in  W  operand A.
- `cmd_b`  in  W  operand B.
- `cmd_op`  in  `alu_opcode_t`  operation.
- `cmd_acc`  in  1  use accumulator instead of `cmd_a` as operand A.
- `alu_a`  out  W  registered drive to `alu.a`.
- `alu_b`  out  W  registered drive to `alu.b`.
- `alu_op`  out  `alu_opcode_t`  registered drive to `alu.op`.
- `alu_result`  in  W  from `alu.result`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  W  captured result.
- `rsp_err`  out  1  opcode was neither `ALU_ADD` nor `ALU_SUB`.
- `acc`  out  W  accumulator value.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
- FIFO:
  - A push occurs when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`, evaluated combinationally from the occupancy count only; there is no bypass when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop at non-full, non-empty occupancy leaves the count unchanged.
  - Pointers wrap modulo `DEPTH`.
- FSM states:
  - **IDLE**: if the FIFO is non-empty, pop the head and load `alu_a` (acc if `cmd_acc`, else `cmd_a`), `alu_b` and `alu_op`, then go to ISSUE. Otherwise stay.
  - **ISSUE**: the ALU settles combinationally. Register `rsp_result = alu_result`, set `rsp_err`, set `rsp_valid = 1`, update acc, then go to RESPOND.
  - **RESPOND**: hold the `rsp_*` signals stable. When `rsp_ready`, clear `rsp_valid` and go to IDLE.
- Accumulator:
  - On ISSUE, `acc <= alu_result` when the opcode is legal.
  - On an illegal opcode, acc is unchanged and `rsp_result = 0` (the ALU default output).
- Arithmetic: results are modulo 2^W; no carry or borrow output. For example, 8'hFF+8'h01 = 8'h00 and 8'h00-8'h01 = 8'hFF.
- `cmd_acc` is captured into the FIFO entry with its command. The operand A substitution uses the acc value current at pop time, which includes all previously completed commands.
- Reset mid-operation:
  - All FIFO contents and any in-flight command are discarded.
  - The FSM goes to IDLE.
  - The response is dropped with no partial handshake.

## Timing
- Reset values:
  - `cmd_ready` = 1, `rsp_valid` = 0, `rsp_result` = 0, `rsp_err` = 0.
  - `alu_a` = 0, `alu_b` = 0, `alu_op` = `ALU_ADD`.
  - `acc` = 0, `busy` = 0.
  - FIFO empty, FSM in IDLE.
- Latency: a command pushed at edge N is popped at edge N+1 (ALU inputs valid during cycle N+1). `rsp_valid` rises after edge N+2. Minimum 2 cycles from accept to response.
- Throughput: one command per 3 cycles when `rsp_ready` is held high (IDLE, ISSUE, RESPOND). Backpressure on `rsp_ready` stalls in RESPOND, and the FIFO continues to fill.
- `alu_a`, `alu_b` and `alu_op` change only on a pop edge. They are stable through ISSUE and RESPOND.
- `busy` is combinational: `!empty || state != IDLE`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-transaction with 3 queued commands and `rsp_valid`=1 → all outputs reach their reset values immediately. After release, `cmd_ready`=1 and no response appears.
- **Basic add/sub (W=8):** push ADD 8'h12/8'h34, then SUB 8'h10/8'h20, with `rsp_ready`=1 → responses 8'h46 then 8'hF0 with `rsp_err`=0. The first `rsp_valid` comes 2 cycles after accept, and the second 3 cycles after the first.
- **Wrap and accumulate:**
  - ADD 8'hFF/8'h01 → 8'h00.
  - Then ADD with `cmd_acc`=1, `cmd_b`=8'h05 → 8'h05.
  - Then SUB with `cmd_acc`=1, `cmd_b`=8'h06 → 8'hFF; `acc`=8'hFF.
- **Illegal opcode:** push an `alu_opcode_t` value that is not ADD/SUB, with A=8'h07, B=8'h01, while acc=8'h33 → `rsp_result`=0, `rsp_err`=1, `acc` stays 8'h33.
- **Full/backpressure (DEPTH=4):**
  - Hold `rsp_ready`=0 and push continuously → 5 commands accepted (1 in flight + 4 queued), then `cmd_ready`=0.
  - `cmd_ready` stays 0 in the cycle a pop coincides with `cmd_valid`.
  - Release `rsp_ready` → 5 responses emerge in order, and `busy` drops after the last handshake.
- **Response stability:** toggle `rsp_ready`=0 for 4 cycles during RESPOND → `rsp_result`, `rsp_err`, `alu_a`, `alu_b` and `alu_op` are unchanged until the handshake.
